alu_muldiv_seq: RTL and testbench

Multi-cycle multiply/divide unit that extends the single-cycle datapath ALU with the RV32M operations (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU).
- Iterative: one shift-add or restore-subtract step per clock.
- Parametrised in operand width.
- Start/done handshake lets the control unit stall the pipeline while BUSY is high.
- Sits beside the ALU in the execute stage; its RESULTADO is multiplexed onto the same write-back path.

---
 rtl/alu_muldiv_seq_if.sv | 24 ++
 rtl/alu_muldiv_seq.sv | 198 +++++++++++++++++++
 tb/tb_alu_muldiv_seq.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_muldiv_seq_if.sv
// alu_muldiv_seq_if: start/done bundle between control unit and muldiv unit.
// master = control unit side, slave = muldiv unit side.
interface alu_muldiv_seq_if #(
  parameter int WIDTH = 32
);
  logic             START;
  logic [2:0]       OP;
  logic [WIDTH-1:0] X;
  logic [WIDTH-1:0] Y;
  logic             BUSY;
  logic             DONE;
  logic [WIDTH-1:0] RESULTADO;
  logic             ZERO;

  modport master (
    output START, OP, X, Y,
    input  BUSY, DONE, RESULTADO, ZERO
  );

  modport slave (
    input  START, OP, X, Y,
    output BUSY, DONE, RESULTADO, ZERO
  );
endinterface

// File: rtl/alu_muldiv_seq.sv
// alu_muldiv_seq: iterative RV32M mul/div, one shift-add/restore step per clock.
// Define ALU_MULDIV_FAST_SPECIAL_EN to skip CALC for trivial/special operands.
module alu_muldiv_seq #(
  parameter int WIDTH = 32
) (
  input logic             CLK,
  input logic             RST_N,
  alu_muldiv_seq_if.slave bus
);
  localparam int CNTW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIN
  } state_t;

  state_t           state_q, state_d;
  logic [CNTW-1:0]  cnt_q, cnt_d;
  logic [2:0]       op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             neg_q, neg_d;
  logic             rneg_q, rneg_d;
  logic             spec_q, spec_d;
  logic [WIDTH-1:0] sres_q, sres_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             zero_q, zero_d;

  logic             accept, last;
  logic             in_div, in_rem;
  logic             sx, sy, sa, sb;
  logic             dz, ovf, mz, spec_now;
  logic [WIDTH-1:0] xm, ym, sres_now;
  logic [WIDTH-1:0] madd;
  logic [WIDTH:0]   msum, dsh;
  logic [WIDTH-1:0] dsub;
  logic             dge;
  logic [WIDTH-1:0] hi_n, lo_n;
  logic [2*WIDTH-1:0] prod, prod_c;
  logic [WIDTH-1:0] quo_c, rem_c, calc_res;

  assign accept = (state_q == IDLE) && bus.START;
  assign last   = (cnt_q == CNTW'(WIDTH - 1));

  // Operand decode at capture
  always_comb begin
    in_div = bus.OP[2];
    in_rem = bus.OP[1];
    sx = in_div ? !bus.OP[0] : (bus.OP[1:0] != 2'b11);
    sy = in_div ? !bus.OP[0] : !bus.OP[1];
    sa = sx & bus.X[WIDTH-1];
    sb = sy & bus.Y[WIDTH-1];
    xm = sa ? -bus.X : bus.X;
    ym = sb ? -bus.Y : bus.Y;
    dz = in_div && (bus.Y == '0);
    ovf = in_div && !bus.OP[0] &&
          (bus.X == {1'b1, {(WIDTH-1){1'b0}}}) &&
          (bus.Y == '1);
`ifdef ALU_MULDIV_FAST_SPECIAL_EN
    mz = !in_div && ((bus.X == '0) || (bus.Y == '0));
`else
    mz = 1'b0;
`endif
    spec_now = dz | ovf | mz;
    unique case (1'b1)
      dz && in_rem:   sres_now = bus.X;
      dz && !in_rem:  sres_now = '1;
      ovf && in_rem:  sres_now = '0;
      ovf && !in_rem: sres_now = bus.X;
      default:        sres_now = '0;
    endcase
  end

  // One iteration step on {hi, lo}
  always_comb begin
    madd = lo_q[0] ? a_q : '0;
    msum = {1'b0, hi_q} + {1'b0, madd};
    dsh  = {hi_q, lo_q[WIDTH-1]};
    dge  = (dsh >= {1'b0, a_q});
    dsub = dsh[WIDTH-1:0] - a_q;
    if (op_q[2]) begin
      hi_n = dge ? dsub : dsh[WIDTH-1:0];
      lo_n = {lo_q[WIDTH-2:0], dge};
    end else begin
      hi_n = msum[WIDTH:1];
      lo_n = {msum[0], lo_q[WIDTH-1:1]};
    end
    prod   = {hi_n, lo_n};
    prod_c = neg_q ? -prod : prod;
    quo_c  = neg_q ? -lo_n : lo_n;
    rem_c  = rneg_q ? -hi_n : hi_n;
    if (spec_q)
      calc_res = sres_q;
    else if (op_q[2])
      calc_res = op_q[1] ? rem_c : quo_c;
    else if (op_q[1:0] == 2'b00)
      calc_res = prod_c[WIDTH-1:0];
    else
      calc_res = prod_c[2*WIDTH-1:WIDTH];
  end

  always_comb begin
    cnt_d  = cnt_q;
    op_d   = op_q;
    a_d    = a_q;
    hi_d   = hi_q;
    lo_d   = lo_q;
    neg_d  = neg_q;
    rneg_d = rneg_q;
    spec_d = spec_q;
    sres_d = sres_q;
    res_d  = res_q;
    zero_d = zero_q;
    if (accept) begin
      cnt_d  = '0;
      op_d   = bus.OP;
      a_d    = in_div ? ym : xm;
      hi_d   = '0;
      lo_d   = in_div ? xm : ym;
      neg_d  = sa ^ sb;
      rneg_d = sa;
      spec_d = spec_now;
      sres_d = sres_now;
`ifdef ALU_MULDIV_FAST_SPECIAL_EN
      if (spec_now) begin
        res_d  = sres_now;
        zero_d = (sres_now == '0);
      end
`endif
    end else if (state_q == CALC) begin
      cnt_d = cnt_q + CNTW'(1);
      hi_d  = hi_n;
      lo_d  = lo_n;
      if (last) begin
        res_d  = calc_res;
        zero_d = (calc_res == '0);
      end
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
`ifdef ALU_MULDIV_FAST_SPECIAL_EN
        if (accept) state_d = spec_now ? FIN : CALC;
`else
        if (accept) state_d = CALC;
`endif
      end
      CALC:    if (last) state_d = FIN;
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.BUSY      = (state_q != IDLE);
    bus.DONE      = (state_q == FIN);
    bus.RESULTADO = res_q;
    bus.ZERO      = zero_q;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      cnt_q  <= '0;
      op_q   <= '0;
      a_q    <= '0;
      hi_q   <= '0;
      lo_q   <= '0;
      neg_q  <= 1'b0;
      rneg_q <= 1'b0;
      spec_q <= 1'b0;
      sres_q <= '0;
      res_q  <= '0;
      zero_q <= 1'b1;
    end else begin
      cnt_q  <= cnt_d;
      op_q   <= op_d;
      a_q    <= a_d;
      hi_q   <= hi_d;
      lo_q   <= lo_d;
      neg_q  <= neg_d;
      rneg_q <= rneg_d;
      spec_q <= spec_d;
      sres_q <= sres_d;
      res_q  <= res_d;
      zero_q <= zero_d;
    end
  end
endmodule

// File: tb/tb_alu_muldiv_seq.sv
// tb_alu_muldiv_seq: directed + random checks of alu_muldiv_seq at WIDTH 32 and 8.
// Expected values come from a plain-arithmetic RV32M model.
module tb_alu_muldiv_seq;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  alu_muldiv_seq_if #(.WIDTH(32)) b32 ();
  alu_muldiv_seq_if #(.WIDTH(8))  b8 ();

  alu_muldiv_seq #(.WIDTH(32)) dut32 (
    .CLK(clk), .RST_N(rst_n), .bus(b32)
  );
  alu_muldiv_seq #(.WIDTH(8)) dut8 (
    .CLK(clk), .RST_N(rst_n), .bus(b8)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mask(int w);
    logic [63:0] m;
    m = (64'd1 << w) - 64'd1;
    return m[31:0];
  endfunction

  function automatic logic [31:0] model(int w, logic [2:0] op,
                                        logic [31:0] x, logic [31:0] y);
    longint ux, uy, sxv, syv, p, r;
    logic [63:0] pu;
    logic [31:0] m;
    m = mask(w);
    ux = longint'(x & m);
    uy = longint'(y & m);
    sxv = x[w-1] ? ux - (longint'(1) << w) : ux;
    syv = y[w-1] ? uy - (longint'(1) << w) : uy;
    case (op)
      3'd0: r = sxv * syv;
      3'd1: r = (sxv * syv) >>> w;
      3'd2: r = (sxv * uy) >>> w;
      3'd3: begin p = ux * uy; pu = p; pu = pu >> w; r = longint'(pu); end
      3'd4: r = (uy == 0) ? -1 : sxv / syv;
      3'd5: r = (uy == 0) ? -1 : ux / uy;
      3'd6: r = (uy == 0) ? ux : sxv % syv;
      default: r = (uy == 0) ? ux : ux % uy;
    endcase
    return 32'(r) & m;
  endfunction

  function automatic int exp_lat(int w, logic [2:0] op,
                                 logic [31:0] x, logic [31:0] y);
    logic [31:0] m, xx, yy;
    bit sp;
    m = mask(w);
    xx = x & m;
    yy = y & m;
    sp = 1'b0;
    if (op[2] && yy == 0) sp = 1'b1;
    if (op[2] && !op[0] && xx == (32'd1 << (w - 1)) && yy == m) sp = 1'b1;
    if (!op[2] && (xx == 0 || yy == 0)) sp = 1'b1;
`ifdef ALU_MULDIV_FAST_SPECIAL_EN
    if (sp) return 1;
`endif
    return sp ? w + 1 : w + 1;
  endfunction

  task automatic drive(int w, logic st, logic [2:0] op,
                       logic [31:0] x, logic [31:0] y);
    if (w == 32) begin
      b32.START = st; b32.OP = op; b32.X = x; b32.Y = y;
    end else begin
      b8.START = st; b8.OP = op; b8.X = x[7:0]; b8.Y = y[7:0];
    end
  endtask

  function automatic logic s_done(int w);
    return (w == 32) ? b32.DONE : b8.DONE;
  endfunction
  function automatic logic s_busy(int w);
    return (w == 32) ? b32.BUSY : b8.BUSY;
  endfunction
  function automatic logic s_zero(int w);
    return (w == 32) ? b32.ZERO : b8.ZERO;
  endfunction
  function automatic logic [31:0] s_res(int w);
    return (w == 32) ? b32.RESULTADO : {24'd0, b8.RESULTADO};
  endfunction

  task automatic run(int w, logic [2:0] op, logic [31:0] x, logic [31:0] y,
                     logic [31:0] e, bit noise, string tag);
    int n, lat;
    @(negedge clk);
    drive(w, 1'b1, op, x, y);
    @(posedge clk);
    #1 drive(w, 1'b0, op, x, y);
    n = 1;
    lat = 0;
    while (lat == 0 && n < 200) begin
      @(negedge clk);
      if (n == 1) check($sformatf("%s_busy1", tag), 32'(s_busy(w)), 32'd1);
      if (s_done(w)) begin
        lat = n;
      end else begin
        if (noise)
          drive(w, 1'($urandom), 3'($urandom), $urandom, $urandom);
        @(posedge clk);
        n++;
      end
    end
    drive(w, 1'b0, op, x, y);
    check($sformatf("%s_lat", tag), 32'(lat), 32'(exp_lat(w, op, x, y)));
    check($sformatf("%s_res", tag), s_res(w), e);
    check($sformatf("%s_zero", tag), 32'(s_zero(w)), 32'(e == 0));
    check($sformatf("%s_busyd", tag), 32'(s_busy(w)), 32'd1);
    @(negedge clk);
    check($sformatf("%s_done1", tag), 32'(s_done(w)), 32'd0);
    check($sformatf("%s_idle", tag), 32'(s_busy(w)), 32'd0);
    check($sformatf("%s_hold", tag), s_res(w), e);
  endtask

  function automatic logic [31:0] pick(int w);
    logic [31:0] v;
    case ($urandom_range(0, 7))
      0: v = 32'd0;
      1: v = 32'd1;
      2: v = 32'hFFFF_FFFF;
      3: v = 32'd1 << (w - 1);
      default: v = $urandom;
    endcase
    return v & mask(w);
  endfunction

  initial begin : main
    int n, first, second, nd;
    logic [2:0] op;
    logic [31:0] x, y;
    rst_n = 1'b0;
    drive(32, 1'b0, 3'd0, 32'd0, 32'd0);
    drive(8, 1'b0, 3'd0, 32'd0, 32'd0);
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 32'(b32.BUSY), 32'd0);
    check("rst_done", 32'(b32.DONE), 32'd0);
    check("rst_res", b32.RESULTADO, 32'd0);
    check("rst_zero", 32'(b32.ZERO), 32'd1);
    check("rst8_res", {24'd0, b8.RESULTADO}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    run(32, 3'd0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b0, "mul");
    run(32, 3'd1, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, "mulh");
    run(32, 3'd3, 32'd7, 32'hFFFF_FFFD, 32'h0000_0006, 1'b0, "mulhu");
    run(32, 3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 1'b0, "div");
    run(32, 3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 1'b0, "rem");
    run(32, 3'd5, 32'd100, 32'd7, 32'd14, 1'b0, "divu");
    run(32, 3'd7, 32'd100, 32'd7, 32'd2, 1'b0, "remu");
    run(32, 3'd5, 32'd5, 32'd0, 32'hFFFF_FFFF, 1'b0, "divu0");
    run(32, 3'd6, 32'd5, 32'd0, 32'd5, 1'b0, "rem0");
    run(32, 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1, "dovf");
    run(32, 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1'b1, "rovf");
    run(8, 3'd4, 32'h80, 32'h03, 32'hD6, 1'b0, "div8");
    run(8, 3'd0, 32'h10, 32'h10, 32'h00, 1'b0, "mul8");

    // START held across two back-to-back operations
    @(negedge clk);
    drive(32, 1'b1, 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    @(posedge clk);
    n = 1;
    first = 0;
    second = 0;
    while (second == 0 && n < 150) begin
      @(negedge clk);
      if (s_done(32)) begin
        if (first == 0) begin
          first = n;
          check("hs_res1", b32.RESULTADO, 32'hFFFF_FFFE);
          drive(32, 1'b1, 3'd0, 32'd3, 32'd4);
        end else begin
          second = n;
        end
      end
      if (n == 34) check("hs_idle", 32'(b32.BUSY), 32'd0);
      if (n == 35) drive(32, 1'b0, 3'd0, 32'd3, 32'd4);
      if (second == 0) begin
        @(posedge clk);
        n++;
      end
    end
    drive(32, 1'b0, 3'd0, 32'd0, 32'd0);
    check("hs_lat1", 32'(first), 32'd33);
    check("hs_lat2", 32'(second), 32'd67);
    check("hs_res2", b32.RESULTADO, 32'd12);

    // asynchronous reset during CALC
    run(32, 3'd0, 32'd9, 32'd9, 32'd81, 1'b0, "prerst");
    @(negedge clk);
    drive(32, 1'b1, 3'd0, 32'd5, 32'd6);
    @(posedge clk);
    #1 drive(32, 1'b0, 3'd0, 32'd5, 32'd6);
    repeat (5) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst_busy", 32'(b32.BUSY), 32'd0);
    check("arst_done", 32'(b32.DONE), 32'd0);
    check("arst_res", b32.RESULTADO, 32'd0);
    check("arst_zero", 32'(b32.ZERO), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    nd = 0;
    repeat (40) begin
      @(negedge clk);
      if (b32.DONE) nd++;
    end
    check("arst_nodone", 32'(nd), 32'd0);

    for (int i = 0; i < 120; i++) begin
      op = 3'($urandom);
      x = pick(32);
      y = pick(32);
      run(32, op, x, y, model(32, op, x, y), 1'($urandom),
          $sformatf("r32_%0d_op%0d", i, op));
    end
    for (int i = 0; i < 120; i++) begin
      op = 3'($urandom);
      x = pick(8);
      y = pick(8);
      run(8, op, x, y, model(8, op, x, y), 1'($urandom),
          $sformatf("r8_%0d_op%0d", i, op));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
